// File: rtl/nv_fifo_ctrl_61x64.sv
// FIFO controller driving an external 61x64 RAM with a two-stage registered read.
// A 3-entry skid buffer after the RAM hides the read latency so pops can run every cycle.
module nv_fifo_ctrl_61x64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_pvld,
  output logic        wr_prdy,
  input  logic [63:0] wr_pd,
  output logic        rd_pvld,
  input  logic        rd_prdy,
  output logic [63:0] rd_pd,
  output logic [5:0]  ram_wa,
  output logic        ram_we,
  output logic [63:0] ram_di,
  output logic [5:0]  ram_ra,
  output logic        ram_re,
  output logic        ram_ore,
  input  logic [63:0] ram_dout,
  output logic [6:0]  fifo_cnt,
  output logic        fifo_idle
);
  localparam logic [5:0] RAM_DEPTH = 6'd61;
  localparam logic [5:0] PTR_LAST  = 6'd60;
  localparam logic [1:0] SKID_LAST = 2'd2;

  logic [5:0]  wr_ptr_q, wr_ptr_d;
  logic [5:0]  rd_ptr_q, rd_ptr_d;
  logic [5:0]  ram_used_q, ram_used_d;
  logic [5:0]  ram_avail_q, ram_avail_d;
  logic        ore_vld_q;
  logic        cap_vld_q;
  logic [1:0]  skid_cnt_q, skid_cnt_d;
  logic [1:0]  skid_head_q, skid_head_d;
  logic [1:0]  skid_tail_q, skid_tail_d;
  logic [63:0] skid_q [3];
  logic        push;
  logic        pop;
  logic        issue;
  logic [2:0]  skid_occ;

  assign wr_prdy = ~rst & (ram_used_q < RAM_DEPTH);
  assign push    = wr_pvld & wr_prdy;
  assign rd_pvld = (skid_cnt_q != 2'd0);
  assign pop     = rd_pvld & rd_prdy;
  assign rd_pd   = skid_q[skid_head_q];

  assign ram_we = push;
  assign ram_wa = wr_ptr_q;
  assign ram_di = wr_pd;

  // Every read still travelling through the RAM pipeline holds a reserved skid slot.
  assign skid_occ = {1'b0, skid_cnt_q} + {2'b00, ore_vld_q} + {2'b00, cap_vld_q};
  assign issue    = (ram_avail_q != 6'd0) & ((skid_occ - {2'b00, pop}) < 3'd3);

  assign ram_re  = issue;
  assign ram_ra  = rd_ptr_q;
  assign ram_ore = ore_vld_q;

  // The word sitting between the ore stage and the skid buffer is not in fifo_cnt.
  assign fifo_cnt  = {1'b0, ram_used_q} + {5'b00000, skid_cnt_q};
  assign fifo_idle = (fifo_cnt == 7'd0) & ~cap_vld_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    skid_head_d = skid_head_q;
    skid_tail_d = skid_tail_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? 6'd0 : wr_ptr_q + 6'd1;
    end
    if (issue) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? 6'd0 : rd_ptr_q + 6'd1;
    end
    if (pop) begin
      skid_head_d = (skid_head_q == SKID_LAST) ? 2'd0 : skid_head_q + 2'd1;
    end
    if (cap_vld_q) begin
      skid_tail_d = (skid_tail_q == SKID_LAST) ? 2'd0 : skid_tail_q + 2'd1;
    end
    ram_used_d  = ram_used_q + {5'b00000, push} - {5'b00000, ore_vld_q};
    ram_avail_d = ram_avail_q + {5'b00000, push} - {5'b00000, issue};
    skid_cnt_d  = skid_cnt_q + {1'b0, cap_vld_q} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_used_q  <= '0;
      ram_avail_q <= '0;
      ore_vld_q   <= 1'b0;
      cap_vld_q   <= 1'b0;
      skid_cnt_q  <= '0;
      skid_head_q <= '0;
      skid_tail_q <= '0;
      for (int i = 0; i < 3; i++) begin
        skid_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_used_q  <= ram_used_d;
      ram_avail_q <= ram_avail_d;
      ore_vld_q   <= issue;
      cap_vld_q   <= ore_vld_q;
      skid_cnt_q  <= skid_cnt_d;
      skid_head_q <= skid_head_d;
      skid_tail_q <= skid_tail_d;
      for (int i = 0; i < 3; i++) begin
        if (cap_vld_q && (skid_tail_q == 2'(i))) begin
          skid_q[i] <= ram_dout;
        end
      end
    end
  end
endmodule

// File: tb/tb_nv_fifo_ctrl_61x64.sv
// Bench for nv_fifo_ctrl_61x64: RAM model, push-recording scoreboard and pop monitor,
// directed scenarios for latency, fill, wrap, full handoff, mid-run reset, then random traffic.
module tb_nv_fifo_ctrl_61x64;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [63:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [63:0] rd_pd;
  logic [5:0]  ram_wa;
  logic        ram_we;
  logic [63:0] ram_di;
  logic [5:0]  ram_ra;
  logic        ram_re;
  logic        ram_ore;
  logic [63:0] ram_dout;
  logic [6:0]  fifo_cnt;
  logic        fifo_idle;

  always #5 clk = ~clk;

  nv_fifo_ctrl_61x64 dut (
    .clk(clk), .rst(rst),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout),
    .fifo_cnt(fifo_cnt), .fifo_idle(fifo_idle)
  );

  // External RAM: address captured on ram_re, data registered on ram_ore.
  logic [63:0] ram_mem [61];
  logic [5:0]  ra_q;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
    if (ram_ore) ram_dout <= ram_mem[ra_q];
  end

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];
  logic [5:0]  exp_wa = 6'd0;
  int used_m = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int issue_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: records accepted pushes as expectations, checks pops against them.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_wa = 6'd0;
      used_m = 0;
    end else begin
      chk1("ram_we_gate", ram_we, wr_pvld & wr_prdy);
      chk1("wr_prdy_vs_used", wr_prdy, used_m < 61);
      if (rd_pvld && rd_prdy) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %h expected no data", rd_pd);
        end else begin
          chk("pop_data", rd_pd, exp_q.pop_front());
        end
      end
      if (ram_we) begin
        chk("ram_wa", 64'(ram_wa), 64'(exp_wa));
        chk("ram_di", ram_di, wr_pd);
        exp_q.push_back(wr_pd);
        exp_wa = (exp_wa == 6'd60) ? 6'd0 : exp_wa + 6'd1;
        push_cnt++;
      end
      if (ram_re) issue_cnt++;
      checks++;
      if (fifo_cnt > 7'd64) begin
        errors++;
        $display("FAIL fifo_cnt_max: got %0d expected <= 64", fifo_cnt);
      end
      used_m = used_m + (ram_we ? 1 : 0) - (ram_ore ? 1 : 0);
    end
  end

  task automatic drive(input logic pv, input logic [63:0] pd, input logic rr);
    @(posedge clk);
    #1;
    wr_pvld = pv;
    wr_pd   = pd;
    rd_prdy = rr;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_rd_pvld"}, rd_pvld, 1'b0);
    chk1({tag, "_wr_prdy"}, wr_prdy, 1'b0);
    chk1({tag, "_ram_we"}, ram_we, 1'b0);
    chk1({tag, "_ram_re"}, ram_re, 1'b0);
    chk1({tag, "_ram_ore"}, ram_ore, 1'b0);
    chk({tag, "_fifo_cnt"}, 64'(fifo_cnt), 64'd0);
    chk1({tag, "_fifo_idle"}, fifo_idle, 1'b1);
    chk({tag, "_rd_pd"}, rd_pd, 64'd0);
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      drive(1'b0, 64'd0, 1'b1);
      smp();
      n++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    drive(1'b0, 64'd0, 1'b0);
    smp();
    chk1({name, "_idle"}, fifo_idle, 1'b1);
    chk({name, "_cnt_zero"}, 64'(fifo_cnt), 64'd0);
  endtask

  initial begin
    int p0, i0, q0, q1, n;
    rst = 1'b1;
    wr_pvld = 1'b0;
    wr_pd = 64'd0;
    rd_prdy = 1'b0;
    #2;
    chk_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    smp();
    chk1("wr_prdy_after_rst", wr_prdy, 1'b1);

    // Single push latency
    drive(1'b1, 64'hA5A5_0000_0000_0001, 1'b1);
    smp();
    chk1("lat_we_W", ram_we, 1'b1);
    chk("lat_wa_W", 64'(ram_wa), 64'd0);
    chk1("lat_re_W", ram_re, 1'b0);
    drive(1'b0, 64'd0, 1'b1);
    smp();
    chk1("lat_re_W1", ram_re, 1'b1);
    chk("lat_ra_W1", 64'(ram_ra), 64'd0);
    chk1("lat_ore_W1", ram_ore, 1'b0);
    smp();
    chk1("lat_ore_W2", ram_ore, 1'b1);
    chk1("lat_re_W2", ram_re, 1'b0);
    smp();
    chk1("lat_pvld_W3", rd_pvld, 1'b0);
    smp();
    chk1("lat_pvld_W4", rd_pvld, 1'b1);
    chk("lat_pd_W4", rd_pd, 64'hA5A5_0000_0000_0001);
    smp();
    chk1("lat_idle", fifo_idle, 1'b1);
    $display("latency test done");

    // Fill with no pops
    do_reset();
    p0 = push_cnt;
    i0 = issue_cnt;
    for (int k = 0; k < 70; k++) drive(1'b1, {32'h2000_0000, 32'(k)}, 1'b0);
    drive(1'b0, 64'd0, 1'b0);
    repeat (4) smp();
    chk("fill_accepts", 64'(push_cnt - p0), 64'd64);
    chk1("fill_wr_prdy", wr_prdy, 1'b0);
    chk("fill_fifo_cnt", 64'(fifo_cnt), 64'd64);
    chk("fill_reads", 64'(issue_cnt - i0), 64'd3);
    chk1("fill_rd_pvld", rd_pvld, 1'b1);
    drain("fill", 200);
    $display("fill test done");

    // Streaming with wrap and throughput
    do_reset();
    p0 = push_cnt;
    q0 = 0;
    for (int k = 0; k < 200; k++) begin
      drive(1'b1, 64'(k), 1'b1);
      if (k == 20) q0 = pop_cnt;
    end
    drive(1'b0, 64'd0, 1'b1);
    q1 = pop_cnt;
    chk("stream_pushes", 64'(push_cnt - p0), 64'd200);
    chk("stream_throughput", 64'(q1 - q0), 64'd180);
    drain("stream", 50);
    $display("stream test done");

    // Full FIFO handoff
    do_reset();
    p0 = push_cnt;
    n = 0;
    while (n < 100) begin
      drive(1'b1, {32'h4000_0000, 32'(n)}, 1'b0);
      smp();
      if (!wr_prdy) break;
      n++;
    end
    chk("full_accepts", 64'(push_cnt - p0), 64'd64);
    drive(1'b1, {32'h4000_0000, 32'(n)}, 1'b1);
    smp();
    chk1("full_refused_on_pop", wr_prdy, 1'b0);
    chk1("full_pop_valid", rd_pvld, 1'b1);
    drive(1'b1, {32'h4000_0000, 32'(n)}, 1'b0);
    smp();
    chk1("full_ore_cycle", ram_ore, 1'b1);
    chk1("full_refused_on_ore", wr_prdy, 1'b0);
    drive(1'b1, {32'h4000_0000, 32'(n)}, 1'b0);
    smp();
    chk1("full_accept_next", wr_prdy, 1'b1);
    chk1("full_we_next", ram_we, 1'b1);
    drive(1'b0, 64'd0, 1'b0);
    smp();
    chk("full_total_pushes", 64'(push_cnt - p0), 64'd65);
    drain("full", 200);
    $display("full handoff test done");

    // Reset mid-operation
    do_reset();
    for (int k = 0; k < 30; k++) drive(1'b1, {32'h5000_0000, 32'(k)}, 1'b0);
    repeat (4) drive(1'b0, 64'd0, 1'b0);
    drive(1'b0, 64'd0, 1'b1);
    drive(1'b0, 64'd0, 1'b1);
    smp();
    chk1("mid_ore_first", ram_ore, 1'b1);
    @(posedge clk);
    #1;
    rd_prdy = 1'b0;
    chk1("mid_two_inflight", ram_ore, 1'b1);
    wr_pvld = 1'b1;
    wr_pd = 64'hBEEF_0000_0000_0024;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    smp();
    chk1("mid_first_we", ram_we, 1'b1);
    chk("mid_first_wa", 64'(ram_wa), 64'd0);
    drive(1'b0, 64'd0, 1'b0);
    n = 0;
    while (!rd_pvld && n < 10) begin
      smp();
      n++;
    end
    chk1("mid_pvld_timeout", rd_pvld, 1'b1);
    chk("mid_first_pop", rd_pd, 64'hBEEF_0000_0000_0024);
    drain("mid", 20);
    $display("mid-run reset test done");

    // Random traffic
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      drive(1'($urandom_range(0, 1)), {32'($urandom), 32'(k)}, 1'($urandom_range(0, 1)));
    end
    drain("rand", 300);
    $display("random test done: %0d pushes, %0d pops total", push_cnt, pop_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
